// File: rtl/ir_tx.sv
// NEC IR transmitter: serialises a 32-bit word (MSB first) or a repeat code
// into a timed envelope, optionally gated by a carrier for the LED.
module ir_tx #(
  parameter int CLK_DIV    = 50,
  parameter int LEAD_H_US  = 9000,
  parameter int LEAD_L_US  = 4500,
  parameter int RPT_L_US   = 2250,
  parameter int BURST_US   = 560,
  parameter int ZERO_L_US  = 560,
  parameter int ONE_L_US   = 1690,
  parameter int CARRIER_EN = 1,
  parameter int CARR_HALF  = 658
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_repeat,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ir_env,
  output logic        o_ir_tx
);

  localparam int TW = 16;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_H, S_LEAD_L, S_BIT_H, S_BIT_L, S_STOP_H, S_DONE
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_tick;
  logic [TW-1:0]   r_ph;
  logic [4:0]      r_bit;
  logic [31:0]     r_sh;
  logic            r_rpt;
  logic [CW-1:0]   r_cc;
  logic            r_carr;

  logic            w_tick;
  logic            w_accept;
  logic [TW-1:0]   w_len;
  logic            w_ph_end;
  logic            w_cc_wrap;
  logic            w_carr_nxt;
  logic            w_tx_on;

  assign w_tick     = (r_tick == DW'(CLK_DIV - 1));
  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_ph_end   = w_tick && (r_ph == w_len - TW'(1));
  assign w_cc_wrap  = (r_cc == CW'(CARR_HALF - 1));
  assign w_carr_nxt = w_cc_wrap ? ~r_carr : r_carr;
  assign w_tx_on    = (CARRIER_EN != 0) ? w_carr_nxt : 1'b1;

  always_comb begin
    w_len = TW'(1);
    case (r_state)
      S_LEAD_H:          w_len = TW'(LEAD_H_US);
      S_LEAD_L:          w_len = r_rpt ? TW'(RPT_L_US) : TW'(LEAD_L_US);
      S_BIT_H, S_STOP_H: w_len = TW'(BURST_US);
      S_BIT_L:           w_len = r_sh[31] ? TW'(ONE_L_US) : TW'(ZERO_L_US);
      default:           w_len = TW'(1);
    endcase
  end

  // Tick divider is re-phased on accept so every phase is an exact multiple of CLK_DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_tick <= '0;
    else if (w_accept || w_tick) r_tick <= '0;
    else                         r_tick <= r_tick + 1'b1;
  end

  // Carrier idles at phase 0/level 1 during spaces, so every burst starts high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc   <= '0;
      r_carr <= 1'b1;
    end else if (!o_ir_env) begin
      r_cc   <= '0;
      r_carr <= 1'b1;
    end else if (w_cc_wrap) begin
      r_cc   <= '0;
      r_carr <= ~r_carr;
    end else begin
      r_cc   <= r_cc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ph     <= '0;
      r_bit    <= '0;
      r_sh     <= '0;
      r_rpt    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_ir_env <= 1'b0;
      o_ir_tx  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (r_state != S_IDLE && r_state != S_DONE && w_tick)
        r_ph <= w_ph_end ? '0 : r_ph + 1'b1;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state  <= S_LEAD_H;
          r_sh     <= i_data;
          r_rpt    <= i_repeat;
          r_ph     <= '0;
          o_busy   <= 1'b1;
          o_ir_env <= 1'b1;
          o_ir_tx  <= 1'b1;
        end
        S_LEAD_H, S_BIT_H, S_STOP_H: begin
          if (w_ph_end) begin
            o_ir_env <= 1'b0;
            o_ir_tx  <= 1'b0;
            if (r_state == S_LEAD_H)     r_state <= S_LEAD_L;
            else if (r_state == S_BIT_H) r_state <= S_BIT_L;
            else begin
              r_state <= S_DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
          end else begin
            o_ir_tx <= w_tx_on;
          end
        end
        S_LEAD_L: if (w_ph_end) begin
          r_state  <= r_rpt ? S_STOP_H : S_BIT_H;
          r_bit    <= '0;
          o_ir_env <= 1'b1;
          o_ir_tx  <= 1'b1;
        end
        S_BIT_L: if (w_ph_end) begin
          r_sh     <= {r_sh[30:0], 1'b0};
          r_bit    <= r_bit + 1'b1;
          r_state  <= (r_bit == 5'd31) ? S_STOP_H : S_BIT_H;
          o_ir_env <= 1'b1;
          o_ir_tx  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
